// File: rtl/bernoulli_arbiter.sv
// bernoulli_arbiter
//   Shares one 7-bit maximal-length LFSR among REQS requesters. One requester
//   is granted per cycle in round-robin order. The granted requester gets a
//   registered Bernoulli bit with P(1) = threshold/127 one cycle later. The
//   block also reseeds the shared source through a one-cycle RELOAD state.
//
//   Optional feature: define BERNOULLI_ARB_STATS_EN to build per-requester
//   16-bit saturating grant and ones counters. When it is undefined,
//   stat_grants and stat_ones are tied to 0.
//
// Ports
//   clk, rst_n   clock, asynchronous active-low reset
//   req          per-requester request, held until granted
//   threshold    per-requester probability numerator, 0..127
//   seed_load    one-cycle pulse that starts a reseed
//   seed         new LFSR value; 0 selects SEED
//   gnt          one-hot grant, combinational
//   rsp_valid    registered response strobe, one cycle per grant
//   rsp_id       index of the requester being answered
//   rsp_bit      Bernoulli result
//   stat_sel     requester selected for statistics readback
//   stat_grants  grant count for stat_sel
//   stat_ones    ones count for stat_sel
module bernoulli_arbiter #(
    parameter int         REQS = 4,
    parameter logic [6:0] SEED = 7'h5A
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [REQS-1:0]             req,
    input  logic [0:REQS-1][6:0]        threshold,
    input  logic                        seed_load,
    input  logic [6:0]                  seed,
    output logic [REQS-1:0]             gnt,
    output logic                        rsp_valid,
    output logic [$clog2(REQS)-1:0]     rsp_id,
    output logic                        rsp_bit,
    input  logic [$clog2(REQS)-1:0]     stat_sel,
    output logic [15:0]                 stat_grants,
    output logic [15:0]                 stat_ones
);

    localparam int IDW = $clog2(REQS);

    typedef enum logic {RUN, RELOAD} state_t;

    state_t         state;
    logic [6:0]     lfsr;
    logic [6:0]     seed_q;
    logic [IDW-1:0] ptr;

    // Round-robin search: first request at or after ptr, wrapping.
    logic           found;
    logic [IDW-1:0] pick;
    int             j;

    always_comb begin
        found = 1'b0;
        pick  = '0;
        j     = 0;
        for (int i = 0; i < REQS; i++) begin
            j = int'(ptr) + i;
            if (j >= REQS) j = j - REQS;
            if (!found && req[j]) begin
                found = 1'b1;
                pick  = IDW'(j);
            end
        end
    end

    // Grant is gated by reset too, so nothing leaks out while rst_n is low.
    logic grant;
    assign grant = rst_n && (state == RUN) && !seed_load && found;

    always_comb begin
        gnt = '0;
        if (grant) gnt[pick] = 1'b1;
    end

    logic draw;
    assign draw = (lfsr <= threshold[pick]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RUN;
            lfsr      <= SEED;
            seed_q    <= SEED;
            ptr       <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_bit   <= 1'b0;
        end else begin
            rsp_valid <= grant;
            case (state)
                RUN: begin
                    if (seed_load) begin
                        // Capture the seed with the pulse; it is applied in RELOAD.
                        seed_q <= (seed == 7'd0) ? SEED : seed;
                        state  <= RELOAD;
                    end else if (grant) begin
                        rsp_id  <= pick;
                        rsp_bit <= draw;
                        lfsr    <= {lfsr[5:0], lfsr[6] ^ lfsr[5]};
                        ptr     <= (pick == IDW'(REQS - 1)) ? '0 : pick + 1'b1;
                    end
                end
                RELOAD: begin
                    // seed_load here is ignored.
                    lfsr  <= seed_q;
                    state <= RUN;
                end
                default: state <= RUN;
            endcase
        end
    end

`ifdef BERNOULLI_ARB_STATS_EN
    logic [15:0] cnt_grants [REQS];
    logic [15:0] cnt_ones   [REQS];

    // Counters follow the response, so they see exactly what requesters see.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < REQS; i++) begin
                cnt_grants[i] <= '0;
                cnt_ones[i]   <= '0;
            end
        end else if (rsp_valid) begin
            if (cnt_grants[rsp_id] != 16'hFFFF)
                cnt_grants[rsp_id] <= cnt_grants[rsp_id] + 16'd1;
            if (rsp_bit && cnt_ones[rsp_id] != 16'hFFFF)
                cnt_ones[rsp_id] <= cnt_ones[rsp_id] + 16'd1;
        end
    end

    assign stat_grants = cnt_grants[stat_sel];
    assign stat_ones   = cnt_ones[stat_sel];
`else
    logic unused_stat_sel;
    assign unused_stat_sel = ^stat_sel;
    assign stat_grants     = 16'd0;
    assign stat_ones       = 16'd0;
`endif

endmodule

// File: tb/tb_bernoulli_arbiter.sv
// Scoreboard bench for bernoulli_arbiter (REQS=4, SEED=0x5A).
// Stimulus pushes expected {id, bit} per grant; a negedge monitor pops and
// compares each response.
module tb_bernoulli_arbiter;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [3:0]      req;
    logic [0:3][6:0] threshold;
    logic            seed_load;
    logic [6:0]      seed;
    logic [3:0]      gnt;
    logic            rsp_valid;
    logic [1:0]      rsp_id;
    logic            rsp_bit;
    logic [1:0]      stat_sel;
    logic [15:0]     stat_grants;
    logic [15:0]     stat_ones;

    bernoulli_arbiter #(.REQS(4), .SEED(7'h5A)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .threshold(threshold),
        .seed_load(seed_load), .seed(seed), .gnt(gnt),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_bit(rsp_bit),
        .stat_sel(stat_sel), .stat_grants(stat_grants), .stat_ones(stat_ones)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] id;
        logic       b;
    } exp_t;

    exp_t       q[$];
    int         n_checks = 0;
    int         n_pass   = 0;
    int         ones_cnt = 0;
    logic [6:0] m_lfsr   = 7'h5A;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    endtask

    // Monitor: every response must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && rsp_valid) begin
            if (q.size() == 0) begin
                chk("unexpected_rsp", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("rsp_id", 32'(rsp_id), 32'(e.id));
                chk("rsp_bit", 32'(rsp_bit), 32'(e.b));
            end
            if (rsp_bit) ones_cnt++;
        end
    end

    // One cycle: drive req, check gnt, record the expected response.
    task automatic step(input logic [3:0] r, input logic [3:0] eg);
        exp_t e;
        req = r;
        #1;
        chk("gnt", 32'(gnt), 32'(eg));
        if (eg != 4'd0) begin
            e.id = 2'd0;
            for (int i = 0; i < 4; i++) if (eg[i]) e.id = 2'(i);
            e.b = (m_lfsr <= threshold[e.id]);
            q.push_back(e);
            m_lfsr = {m_lfsr[5:0], m_lfsr[6] ^ m_lfsr[5]};
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        q.delete();
        m_lfsr = 7'h5A;
        req = 4'd0;
        seed_load = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    logic [3:0] rr_all [8] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
                               4'b0001, 4'b0010, 4'b0100, 4'b1000};
    logic [3:0] rr_alt [4] = '{4'b0001, 4'b0100, 4'b0001, 4'b0100};

    initial begin
        rst_n     = 1'b0;
        req       = 4'b0001;
        threshold = '{7'd90, 7'd0, 7'd0, 7'd0};
        seed_load = 1'b0;
        seed      = 7'd0;
        stat_sel  = 2'd0;

        // Reset state with a request already pending.
        #2;
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_id", 32'(rsp_id), 32'd0);
        chk("rst_rsp_bit", 32'(rsp_bit), 32'd0);
        chk("rst_stat_grants", 32'(stat_grants), 32'd0);
        chk("rst_stat_ones", 32'(stat_ones), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // First draw: 0x5A <= 90 gives 1.
        step(4'b0001, 4'b0001);
        chk("first_rsp_valid", 32'(rsp_valid), 32'd1);
        step(4'b0000, 4'b0000);

        // Round-robin. One grant to 3 brings ptr back to 0.
        step(4'b1000, 4'b1000);
        for (int i = 0; i < 8; i++) step(4'b1111, rr_all[i]);
        for (int i = 0; i < 4; i++) step(4'b0101, rr_alt[i]);
        step(4'b0000, 4'b0000);

        // Extreme probabilities.
        threshold[2] = 7'd0;
        ones_cnt = 0;
        for (int i = 0; i < 8; i++) step(4'b0100, 4'b0100);
        step(4'b0000, 4'b0000);
        chk("thr0_ones", 32'(ones_cnt), 32'd0);
        threshold[3] = 7'd127;
        ones_cnt = 0;
        for (int i = 0; i < 8; i++) step(4'b1000, 4'b1000);
        step(4'b0000, 4'b0000);
        chk("thr127_ones", 32'(ones_cnt), 32'd8);

        // Exact probability over ten full LFSR periods.
        do_reset();
        threshold[0] = 7'd64;
        ones_cnt = 0;
        for (int i = 0; i < 1270; i++) step(4'b0001, 4'b0001);
        step(4'b0000, 4'b0000);
        chk("thr64_ones", 32'(ones_cnt), 32'd640);
        stat_sel = 2'd0;
        #1;
`ifdef BERNOULLI_ARB_STATS_EN
        chk("stat_grants_1270", 32'(stat_grants), 32'd1270);
        chk("stat_ones_640", 32'(stat_ones), 32'd640);
`else
        chk("stat_grants_off", 32'(stat_grants), 32'd0);
        chk("stat_ones_off", 32'(stat_ones), 32'd0);
`endif

        // Reseed to 1 while requesting; a second pulse in RELOAD is ignored.
        threshold[0] = 7'd1;
        seed = 7'h01;
        seed_load = 1'b1;
        step(4'b0001, 4'b0000);
        step(4'b0001, 4'b0000);
        seed_load = 1'b0;
        m_lfsr = 7'h01;
        ones_cnt = 0;
        for (int i = 0; i < 127; i++) step(4'b0001, 4'b0001);
        step(4'b0000, 4'b0000);
        chk("reseed1_ones", 32'(ones_cnt), 32'd1);

        // Zero seed selects 0x5A: 90 > 89 gives 0, then 0x35 <= 89 gives 1.
        threshold[0] = 7'd89;
        seed = 7'h00;
        seed_load = 1'b1;
        step(4'b0001, 4'b0000);
        seed_load = 1'b0;
        step(4'b0001, 4'b0000);
        m_lfsr = 7'h5A;
        ones_cnt = 0;
        step(4'b0001, 4'b0001);
        step(4'b0001, 4'b0001);
        step(4'b0000, 4'b0000);
        chk("reseed0_ones", 32'(ones_cnt), 32'd1);

        // Mid-operation reset drops the in-flight response at once.
        threshold[0] = 7'd90;
        step(4'b0001, 4'b0001);
        chk("pre_rst_valid", 32'(rsp_valid), 32'd1);
        rst_n = 1'b0;
        q.delete();
        m_lfsr = 7'h5A;
        #1;
        chk("midrst_valid", 32'(rsp_valid), 32'd0);
        chk("midrst_gnt", 32'(gnt), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(4'b1111, 4'b0001);
        step(4'b0000, 4'b0000);

        // Saturation of the statistics counters.
        stat_sel = 2'd1;
`ifdef BERNOULLI_ARB_STATS_EN
        threshold[1] = 7'd127;
        for (int i = 0; i < 70000; i++) step(4'b0010, 4'b0010);
        step(4'b0000, 4'b0000);
        chk("sat_grants", 32'(stat_grants), 32'hFFFF);
        chk("sat_ones", 32'(stat_ones), 32'hFFFF);
`else
        for (int i = 0; i < 20; i++) step(4'b0010, 4'b0010);
        step(4'b0000, 4'b0000);
        chk("stat_grants_off_end", 32'(stat_grants), 32'd0);
        chk("stat_ones_off_end", 32'(stat_ones), 32'd0);
`endif

        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/bernoulli_arbiter.md
# bernoulli_arbiter

Shares one maximal-length 7-bit LFSR Bernoulli source among `REQS` requesters, typically the per-column STDP update units of a TNN layer, which each need random decisions at their own probability. It grants one requester per cycle, round-robin. For the granted requester it returns a registered Bernoulli bit with P(1) = `threshold`/127. It also owns reseeding of the shared source.

## Interface
- `REQS`, 4: number of requesters, 2..16.
- `SEED`, 7'h5A: LFSR value after reset and on a zero-seed load; must be nonzero.
- `clk` input 1: clock.
- `rst_n` input 1: reset, asynchronous, active-low.
- `req` input `REQS`: per-requester request; held high until granted.
- `threshold` input `[0:REQS-1][6:0]`: per-requester probability numerator, 0..127.
- `seed_load` input 1: one-cycle pulse that reseeds the LFSR.
- `seed` input 7: new LFSR value; 0 means use `SEED`.
- `gnt` output `REQS`: one-hot grant, combinational, same cycle as the accepted `req`.
- `rsp_valid` output 1: response valid, registered.
- `rsp_id` output `$clog2(REQS)`: index of the requester being answered.
- `rsp_bit` output 1: Bernoulli result.
- `stat_sel` input `$clog2(REQS)`: selects a requester for statistics readback.
- `stat_grants` output 16: grant count for `stat_sel`.
- `stat_ones` output 16: ones count for `stat_sel`.

## Operation
- **LFSR.** 7-bit Fibonacci LFSR, polynomial x^7+x^6+1, next = {lfsr[5:0], lfsr[6]^lfsr[5]}. It visits 1..127 and never 0. It advances only in a cycle with a grant.
- **Bernoulli rule.** `rsp_bit` = (lfsr <= threshold[g]), where g is the granted index. Both operands are unsigned 7-bit. threshold 0 always gives 0; threshold 127 always gives 1.
- **FSM states:**
  - RUN: grants allowed.
  - RELOAD: no grants. The LFSR loads `seed`, or `SEED` if `seed` is 0.
- **FSM transitions:**
  - RUN → RELOAD when `seed_load`=1. The grant is suppressed in that cycle.
  - RELOAD → RUN unconditionally after one cycle.
  - `seed_load` asserted while in RELOAD is ignored.
- **Arbitration.** Round-robin pointer `ptr`, reset value 0. The granted index is the first `req` bit at or after `ptr`, wrapping modulo `REQS`. After granting g, `ptr` becomes (g+1) mod `REQS`. `ptr` is unchanged when there is no grant.
- **Requester contract.** A requester deasserts `req` in the cycle after its `gnt`, or keeps it high to request again. Dropping `req` before a grant is legal; no response is produced.

## Timing
- `gnt` is combinational from `req`, `ptr` and state. It is all zeros in RELOAD, in a `seed_load` cycle, and during reset.
- Response latency is 1 cycle. A grant at cycle N produces `rsp_valid`=1 at N+1, carrying `rsp_id`=g and the bit computed from the cycle-N LFSR and threshold.
- `rsp_valid` is high for exactly one cycle per grant. Back-to-back grants give back-to-back responses.
- Reset values:
  - `gnt`=0, `rsp_valid`=0, `rsp_id`=0, `rsp_bit`=0.
  - `ptr`=0, lfsr=`SEED`, state=RUN.
  - `stat_grants`=0 and `stat_ones`=0 for all requesters.
- Reset mid-operation discards any in-flight response: `rsp_valid` falls asynchronously with `rst_n`.
- `seed_load` coinciding with `req` gives no grant. Requests are served starting 2 cycles later, from the new seed.

## Configuration
- `BERNOULLI_ARB_STATS_EN` defined:
  - Per-requester 16-bit grant and ones counters, saturating at 16'hFFFF.
  - Counters update at response time (N+1).
  - `stat_grants` and `stat_ones` read `stat_sel` combinationally.
  - Counters clear only on reset.
- `BERNOULLI_ARB_STATS_EN` undefined:
  - No counters are built.
  - `stat_grants` and `stat_ones` are tied to 0; `stat_sel` is ignored.

## Test plan
- **Reset values and first draw.** Reset, then `req`=4'b0001, threshold[0]=90.
  - During and after reset: every output is 0.
  - `gnt`=4'b0001 at once.
  - Next cycle: `rsp_valid`=1, `rsp_id`=0, `rsp_bit`=1 (since 0x5A=90 <= 90).
- **Round-robin.** `req`=4'b1111 held for 8 cycles → `gnt` sequence 1,2,4,8,1,2,4,8. With `req`=4'b0101 held → requesters 0,2,0,2.
- **Extreme and exact probabilities.**
  - threshold 0 → `rsp_bit`=0 on every response.
  - threshold 127 → `rsp_bit`=1 on every response.
  - threshold 64 over 1270 consecutive grants → exactly 640 ones. With the stats macro enabled, `stat_ones`=640 and `stat_grants`=1270.
- **Reseed.**
  - `seed_load`=1 with `seed`=7'h01 while `req` is held → no `gnt` for 2 cycles, then the first draw uses lfsr=1.
  - threshold 1 → `rsp_bit`=1 on that draw, then 0 for the next 126 draws.
  - `seed`=0 → the following draw uses 0x5A.
- **Mid-operation reset.** Assert `rst_n`=0 in the cycle after a grant → `rsp_valid` drops immediately. After release, `ptr`=0 and lfsr=0x5A.
- **Stats saturation.** With the macro enabled, 70000 grants to requester 1 → `stat_grants`=16'hFFFF. Without the macro, the stats outputs stay 0 throughout.
